logic_axi4_lite_to_avalon_mm_pipelined: RTL and testbench

Next-generation AXI4-Lite slave to Avalon-MM master bridge with pipelined reads, bounded outstanding transactions and read/write arbitration. It converts AXI4-Lite AW/W/AR requests into a single registered Avalon-MM command stream and returns responses through depth-bounded R and B FIFOs. It sits between AXI4-Lite interconnect and Avalon-MM peripherals that use `readdatavalid` (variable read latency).

---
 rtl/logic_axi4_lite_to_avalon_mm_pipelined.sv | 225 ++++++++++++++++++++++
 tb/tb_logic_axi4_lite_to_avalon_mm_pipelined.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_lite_to_avalon_mm_pipelined.sv
// AXI4-Lite slave to Avalon-MM master bridge: one registered command stage, credit-bounded
// outstanding reads/writes and R/B response FIFOs. Optional: LOGIC_AXI4_LITE_TO_AVALON_MM_PIPELINED_WRITE_RESPONSE_EN
module logic_axi4_lite_to_avalon_mm_pipelined #(
    parameter int DATA_BYTES         = 4,
    parameter int ADDRESS_WIDTH      = 1,
    parameter int MAX_PENDING_READS  = 4,
    parameter int MAX_PENDING_WRITES = 4
) (
    input  logic                      i_aclk,
    input  logic                      i_areset,
    input  logic [ADDRESS_WIDTH-1:0]  i_s_awaddr,
    input  logic                      i_s_awvalid,
    output logic                      o_s_awready,
    input  logic [8*DATA_BYTES-1:0]   i_s_wdata,
    input  logic [DATA_BYTES-1:0]     i_s_wstrb,
    input  logic                      i_s_wvalid,
    output logic                      o_s_wready,
    output logic [1:0]                o_s_bresp,
    output logic                      o_s_bvalid,
    input  logic                      i_s_bready,
    input  logic [ADDRESS_WIDTH-1:0]  i_s_araddr,
    input  logic                      i_s_arvalid,
    output logic                      o_s_arready,
    output logic [8*DATA_BYTES-1:0]   o_s_rdata,
    output logic [1:0]                o_s_rresp,
    output logic                      o_s_rvalid,
    input  logic                      i_s_rready,
    output logic                      o_m_read,
    output logic                      o_m_write,
    output logic [ADDRESS_WIDTH-1:0]  o_m_address,
    output logic [8*DATA_BYTES-1:0]   o_m_writedata,
    output logic [DATA_BYTES-1:0]     o_m_byteenable,
    input  logic                      i_m_waitrequest,
    input  logic [8*DATA_BYTES-1:0]   i_m_readdata,
    input  logic                      i_m_readdatavalid,
    input  logic [1:0]                i_m_response,
    input  logic                      i_m_writeresponsevalid
);
    localparam int DW  = 8 * DATA_BYTES;
    localparam int RCW = $clog2(MAX_PENDING_READS + 1);
    localparam int WCW = $clog2(MAX_PENDING_WRITES + 1);
    localparam int RPW = (MAX_PENDING_READS > 1) ? $clog2(MAX_PENDING_READS) : 1;
    localparam int WPW = (MAX_PENDING_WRITES > 1) ? $clog2(MAX_PENDING_WRITES) : 1;
    localparam logic [RCW-1:0] R_MAX  = RCW'(MAX_PENDING_READS);
    localparam logic [WCW-1:0] W_MAX  = WCW'(MAX_PENDING_WRITES);
    localparam logic [RPW-1:0] R_LAST = RPW'(MAX_PENDING_READS - 1);
    localparam logic [WPW-1:0] W_LAST = WPW'(MAX_PENDING_WRITES - 1);

    function automatic logic [1:0] map_resp(input logic [1:0] avl);
        case (avl)
            2'b00:   map_resp = 2'b00;
            2'b11:   map_resp = 2'b11;
            default: map_resp = 2'b10;
        endcase
    endfunction

    logic                     r_read, r_write, r_prio_wr;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DW-1:0]            r_writedata;
    logic [DATA_BYTES-1:0]    r_byteenable;
    logic [RCW-1:0]           r_pend_r, r_rf_cnt;
    logic [WCW-1:0]           r_pend_w, r_bf_cnt;
    logic [DW+1:0]            r_rf_mem [MAX_PENDING_READS];
    logic [1:0]               r_bf_mem [MAX_PENDING_WRITES];
    logic [RPW-1:0]           r_rf_wptr, r_rf_rptr;
    logic [WPW-1:0]           r_bf_wptr, r_bf_rptr;

    logic w_cmd_free, w_wr_cand, w_rd_cand, w_contested;
    logic w_wr_grant, w_rd_grant;
    logic w_r_push, w_r_pop, w_b_push, w_b_pop;
    logic [1:0] w_b_data;

    assign w_cmd_free  = ~(r_read | r_write) | ~i_m_waitrequest;
    assign w_wr_cand   = i_s_awvalid & i_s_wvalid & (r_pend_w < W_MAX);
    assign w_rd_cand   = i_s_arvalid & (r_pend_r < R_MAX);
    assign w_contested = w_cmd_free & w_wr_cand & w_rd_cand & ~i_areset;

    // Grant one request per free command slot; ties go to the current priority side
    always_comb begin
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        if (w_cmd_free && !i_areset) begin
            if (w_wr_cand && w_rd_cand) begin
                w_wr_grant = r_prio_wr;
                w_rd_grant = ~r_prio_wr;
            end else begin
                w_wr_grant = w_wr_cand;
                w_rd_grant = w_rd_cand;
            end
        end else begin
            w_wr_grant = 1'b0;
            w_rd_grant = 1'b0;
        end
    end

    assign o_s_awready    = w_wr_grant;
    assign o_s_wready     = w_wr_grant;
    assign o_s_arready    = w_rd_grant;
    assign o_m_read       = r_read;
    assign o_m_write      = r_write;
    assign o_m_address    = r_address;
    assign o_m_writedata  = r_writedata;
    assign o_m_byteenable = r_byteenable;

    assign o_s_rvalid = (r_rf_cnt != {RCW{1'b0}});
    assign o_s_rdata  = r_rf_mem[r_rf_rptr][DW+1:2];
    assign o_s_rresp  = r_rf_mem[r_rf_rptr][1:0];
    assign o_s_bvalid = (r_bf_cnt != {WCW{1'b0}});
    assign o_s_bresp  = r_bf_mem[r_bf_rptr];

    // Responses with no matching outstanding request (e.g. stale after reset) are dropped
    assign w_r_push = i_m_readdatavalid & (r_pend_r != {RCW{1'b0}}) & (r_rf_cnt != R_MAX);
    assign w_r_pop  = o_s_rvalid & i_s_rready;
    assign w_b_pop  = o_s_bvalid & i_s_bready;
`ifdef LOGIC_AXI4_LITE_TO_AVALON_MM_PIPELINED_WRITE_RESPONSE_EN
    assign w_b_push = i_m_writeresponsevalid & (r_pend_w != {WCW{1'b0}}) & (r_bf_cnt != W_MAX);
    assign w_b_data = map_resp(i_m_response);
`else
    logic w_unused_wrv;
    assign w_unused_wrv = i_m_writeresponsevalid;
    assign w_b_push = r_write & ~i_m_waitrequest & (r_bf_cnt != W_MAX);
    assign w_b_data = 2'b00;
`endif

    // Command stage: reload whenever the held command is gone or being accepted
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= {ADDRESS_WIDTH{1'b0}};
            r_writedata  <= {DW{1'b0}};
            r_byteenable <= {DATA_BYTES{1'b0}};
        end else if (w_cmd_free) begin
            if (w_wr_grant) begin
                r_read       <= 1'b0;
                r_write      <= 1'b1;
                r_address    <= i_s_awaddr;
                r_writedata  <= i_s_wdata;
                r_byteenable <= i_s_wstrb;
            end else if (w_rd_grant) begin
                r_read       <= 1'b1;
                r_write      <= 1'b0;
                r_address    <= i_s_araddr;
                r_writedata  <= {DW{1'b0}};
                r_byteenable <= {DATA_BYTES{1'b1}};
            end else begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
            end
        end
    end

    // Round-robin flag flips only on contested grants
    always_ff @(posedge i_aclk) begin
        if (i_areset)
            r_prio_wr <= 1'b1;
        else if (w_contested)
            r_prio_wr <= ~r_prio_wr;
    end

    // Credit counters and FIFO occupancy
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_pend_r <= {RCW{1'b0}};
            r_pend_w <= {WCW{1'b0}};
            r_rf_cnt <= {RCW{1'b0}};
            r_bf_cnt <= {WCW{1'b0}};
        end else begin
            case ({w_rd_grant, w_r_pop})
                2'b10:   r_pend_r <= r_pend_r + RCW'(1);
                2'b01:   r_pend_r <= r_pend_r - RCW'(1);
                default: r_pend_r <= r_pend_r;
            endcase
            case ({w_wr_grant, w_b_pop})
                2'b10:   r_pend_w <= r_pend_w + WCW'(1);
                2'b01:   r_pend_w <= r_pend_w - WCW'(1);
                default: r_pend_w <= r_pend_w;
            endcase
            case ({w_r_push, w_r_pop})
                2'b10:   r_rf_cnt <= r_rf_cnt + RCW'(1);
                2'b01:   r_rf_cnt <= r_rf_cnt - RCW'(1);
                default: r_rf_cnt <= r_rf_cnt;
            endcase
            case ({w_b_push, w_b_pop})
                2'b10:   r_bf_cnt <= r_bf_cnt + WCW'(1);
                2'b01:   r_bf_cnt <= r_bf_cnt - WCW'(1);
                default: r_bf_cnt <= r_bf_cnt;
            endcase
        end
    end

    // R FIFO storage and pointers
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            for (int i = 0; i < MAX_PENDING_READS; i++)
                r_rf_mem[i] <= {(DW+2){1'b0}};
            r_rf_wptr <= {RPW{1'b0}};
            r_rf_rptr <= {RPW{1'b0}};
        end else begin
            if (w_r_push) begin
                r_rf_mem[r_rf_wptr] <= {i_m_readdata, map_resp(i_m_response)};
                r_rf_wptr <= (r_rf_wptr == R_LAST) ? {RPW{1'b0}} : r_rf_wptr + RPW'(1);
            end
            if (w_r_pop)
                r_rf_rptr <= (r_rf_rptr == R_LAST) ? {RPW{1'b0}} : r_rf_rptr + RPW'(1);
        end
    end

    // B FIFO storage and pointers
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            for (int i = 0; i < MAX_PENDING_WRITES; i++)
                r_bf_mem[i] <= 2'b00;
            r_bf_wptr <= {WPW{1'b0}};
            r_bf_rptr <= {WPW{1'b0}};
        end else begin
            if (w_b_push) begin
                r_bf_mem[r_bf_wptr] <= w_b_data;
                r_bf_wptr <= (r_bf_wptr == W_LAST) ? {WPW{1'b0}} : r_bf_wptr + WPW'(1);
            end
            if (w_b_pop)
                r_bf_rptr <= (r_bf_rptr == W_LAST) ? {WPW{1'b0}} : r_bf_rptr + WPW'(1);
        end
    end
endmodule

// File: tb/tb_logic_axi4_lite_to_avalon_mm_pipelined.sv
// Directed self-checking bench for the AXI4-Lite to Avalon-MM bridge (works with or without
// LOGIC_AXI4_LITE_TO_AVALON_MM_PIPELINED_WRITE_RESPONSE_EN).
module tb_logic_axi4_lite_to_avalon_mm_pipelined;
    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] awaddr, araddr, wdata, readdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        waitrequest, readdatavalid, writeresponsevalid;
    logic [1:0]  response;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        m_read, m_write;
    logic [31:0] m_address, m_writedata;
    logic [3:0]  m_byteenable;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_axi4_lite_to_avalon_mm_pipelined #(
        .DATA_BYTES(4), .ADDRESS_WIDTH(32), .MAX_PENDING_READS(4), .MAX_PENDING_WRITES(4)
    ) dut (
        .i_aclk(clk), .i_areset(areset),
        .i_s_awaddr(awaddr), .i_s_awvalid(awvalid), .o_s_awready(awready),
        .i_s_wdata(wdata), .i_s_wstrb(wstrb), .i_s_wvalid(wvalid), .o_s_wready(wready),
        .o_s_bresp(bresp), .o_s_bvalid(bvalid), .i_s_bready(bready),
        .i_s_araddr(araddr), .i_s_arvalid(arvalid), .o_s_arready(arready),
        .o_s_rdata(rdata), .o_s_rresp(rresp), .o_s_rvalid(rvalid), .i_s_rready(rready),
        .o_m_read(m_read), .o_m_write(m_write), .o_m_address(m_address),
        .o_m_writedata(m_writedata), .o_m_byteenable(m_byteenable),
        .i_m_waitrequest(waitrequest), .i_m_readdata(readdata),
        .i_m_readdatavalid(readdatavalid), .i_m_response(response),
        .i_m_writeresponsevalid(writeresponsevalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        settle();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, m_read, m_write} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {awready, wready, arready, bvalid, rvalid, m_read, m_write});
        end
        checks++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_resp: got %h expected 0", {bresp, rresp, rdata});
        end
        checks++;
        if ({m_address, m_writedata, m_byteenable} !== 68'h0) begin
            errors++;
            $display("FAIL reset_cmd: got %h expected 0", {m_address, m_writedata, m_byteenable});
        end
    endtask

    task automatic test_single_write();
        awaddr = 32'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        settle();
        checks++;
        if ({awready, wready, m_write} !== 3'b110) begin
            errors++;
            $display("FAIL wr_grant: got %b expected 110", {awready, wready, m_write});
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
`ifdef LOGIC_AXI4_LITE_TO_AVALON_MM_PIPELINED_WRITE_RESPONSE_EN
        writeresponsevalid = 1'b1; response = 2'b00;
`endif
        settle();
        checks++;
        if ({m_write, m_read, awready, wready} !== 4'b1000) begin
            errors++;
            $display("FAIL wr_cmd_ctrl: got %b expected 1000", {m_write, m_read, awready, wready});
        end
        checks++;
        if ({m_address, m_writedata, m_byteenable} !== {32'h4, 32'hDEADBEEF, 4'hF}) begin
            errors++;
            $display("FAIL wr_cmd_fields: got %h expected %h", {m_address, m_writedata, m_byteenable}, {32'h4, 32'hDEADBEEF, 4'hF});
        end
        tick();
        writeresponsevalid = 1'b0;
        settle();
        checks++;
        if ({m_write, bvalid, bresp} !== 4'b0100) begin
            errors++;
            $display("FAIL wr_bresp: got %b expected 0100", {m_write, bvalid, bresp});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        settle();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_bpop: got %b expected 0", bvalid);
        end
    endtask

    task automatic test_read_burst();
        int grants = 0;
        int reads = 0;
        int bad = 0;
        logic [31:0] exp_addr;
        rready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            arvalid = (grants < 6);
            araddr = 32'h100 + 32'(4 * grants);
            settle();
            if (m_read) begin
                exp_addr = 32'h100 + 32'(4 * reads);
                if (m_address !== exp_addr || m_byteenable !== 4'hF) bad++;
                reads++;
            end
            if (arready) grants++;
            tick();
        end
        checks++;
        if (grants != 4 || reads != 4) begin
            errors++;
            $display("FAIL rd_credit: got grants=%0d reads=%0d expected 4 and 4", grants, reads);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rd_cmd_fields: got %0d bad commands expected 0", bad);
        end
        arvalid = 1'b1; araddr = 32'h110;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            readdatavalid = 1'b1; readdata = 32'hA000_0000 + 32'(i); response = 2'b00;
            settle();
            if (arready !== 1'b0) bad++;
            tick();
        end
        readdatavalid = 1'b0;
        rready = 1'b1;
        settle();
        checks++;
        if (bad != 0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL rd_block: got %0d early grants expected 0", bad);
        end
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hA000_0000}) begin
            errors++;
            $display("FAIL rd_first: got %h expected %h", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hA000_0000});
        end
        tick();
        rready = 1'b0;
        settle();
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_credit_return: got %b expected 1", arready);
        end
        tick();
        arvalid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            rready = 1'b1;
            readdatavalid = (i == 2);
            readdata = 32'hA000_0004;
            settle();
            if (i == 1) begin
                checks++;
                if ({m_read, m_address} !== {1'b1, 32'h110}) begin
                    errors++;
                    $display("FAIL rd_fifth_cmd: got %h expected %h", {m_read, m_address}, {1'b1, 32'h110});
                end
            end
            checks++;
            if ({rvalid, rdata} !== {1'b1, 32'hA000_0000 + 32'(i)}) begin
                errors++;
                $display("FAIL rd_order_%0d: got %h expected %h", i, {rvalid, rdata}, {1'b1, 32'hA000_0000 + 32'(i)});
            end
            tick();
        end
        rready = 1'b0;
        readdatavalid = 1'b0;
        settle();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_drained: got %b expected 0", rvalid);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_rdy;
        logic [1:0] exp_cmd;
        bready = 1'b1; rready = 1'b1;
        awaddr = 32'h20; wdata = 32'h1111_1111; wstrb = 4'hF; araddr = 32'h30;
        for (int k = 0; k < 5; k++) begin
            awvalid = (k < 4); wvalid = (k < 4); arvalid = (k < 4);
            settle();
            if (k < 4) begin
                exp_rdy = (k % 2 == 0) ? 3'b110 : 3'b001;
                checks++;
                if ({awready, wready, arready} !== exp_rdy) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: got %b expected %b", k, {awready, wready, arready}, exp_rdy);
                end
            end
            if (k > 0) begin
                exp_cmd = ((k - 1) % 2 == 0) ? 2'b10 : 2'b01;
                checks++;
                if ({m_write, m_read} !== exp_cmd) begin
                    errors++;
                    $display("FAIL rr_cmd_%0d: got %b expected %b", k, {m_write, m_read}, exp_cmd);
                end
            end
            tick();
        end
        readdatavalid = 1'b1; readdata = 32'hB0; response = 2'b00;
`ifdef LOGIC_AXI4_LITE_TO_AVALON_MM_PIPELINED_WRITE_RESPONSE_EN
        writeresponsevalid = 1'b1;
`endif
        tick();
        readdata = 32'hB1;
        settle();
        checks++;
        if ({rvalid, rdata} !== {1'b1, 32'hB0}) begin
            errors++;
            $display("FAIL rr_rdata0: got %h expected %h", {rvalid, rdata}, {1'b1, 32'hB0});
        end
        tick();
        readdatavalid = 1'b0; writeresponsevalid = 1'b0;
        settle();
        checks++;
        if ({rvalid, rdata} !== {1'b1, 32'hB1}) begin
            errors++;
            $display("FAIL rr_rdata1: got %h expected %h", {rvalid, rdata}, {1'b1, 32'hB1});
        end
        tick();
        tick();
        bready = 1'b0; rready = 1'b0;
        settle();
        checks++;
        if ({bvalid, rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rr_drained: got %b expected 00", {bvalid, rvalid});
        end
    endtask

    task automatic test_error_mapping();
        logic [1:0] avl [3];
        logic [1:0] exp [3];
        avl = '{2'b01, 2'b10, 2'b11};
        exp = '{2'b10, 2'b10, 2'b11};
        arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            araddr = 32'h40 + 32'(4 * i);
            tick();
        end
        arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            readdatavalid = 1'b1; readdata = 32'hC0 + 32'(i); response = avl[i];
        end
        tick();
        readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rready = 1'b1;
            settle();
            checks++;
            if ({rvalid, rresp, rdata} !== {1'b1, exp[i], 32'hC0 + 32'(i)}) begin
                errors++;
                $display("FAIL err_map_%0d: got %h expected %h", i, {rvalid, rresp, rdata}, {1'b1, exp[i], 32'hC0 + 32'(i)});
            end
            tick();
        end
        rready = 1'b0;
`ifdef LOGIC_AXI4_LITE_TO_AVALON_MM_PIPELINED_WRITE_RESPONSE_EN
        awaddr = 32'h50; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        writeresponsevalid = 1'b1; response = 2'b10;
        tick();
        writeresponsevalid = 1'b0;
        settle();
        checks++;
        if ({bvalid, bresp} !== 3'b110) begin
            errors++;
            $display("FAIL err_bresp: got %b expected 110", {bvalid, bresp});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
`endif
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        int grants = 0;
        waitrequest = 1'b1;
        awaddr = 32'h60; wdata = 32'h1234_5678; wstrb = 4'h3;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awaddr = 32'h64; wdata = 32'h9ABC_DEF0; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h68;
        for (int c = 0; c < 5; c++) begin
            settle();
            if ({m_write, m_read, m_address, m_writedata, m_byteenable} !== {2'b10, 32'h60, 32'h1234_5678, 4'h3})
                unstable++;
            if (awready || wready || arready) grants++;
            tick();
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable);
        end
        checks++;
        if (grants != 0) begin
            errors++;
            $display("FAIL bp_no_grant: got %0d grants expected 0", grants);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        waitrequest = 1'b0;
        tick();
`ifdef LOGIC_AXI4_LITE_TO_AVALON_MM_PIPELINED_WRITE_RESPONSE_EN
        writeresponsevalid = 1'b1; response = 2'b00;
        tick();
        writeresponsevalid = 1'b0;
`endif
        settle();
        checks++;
        if ({m_write, bvalid, bresp} !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release: got %b expected 0100", {m_write, bvalid, bresp});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_reset_midop();
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h80;
        tick();
        araddr = 32'h84;
        tick();
        areset = 1'b1; araddr = 32'h88;
        settle();
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_grant: got %b expected 0", arready);
        end
        arvalid = 1'b0;
        tick();
        areset = 1'b0;
        readdatavalid = 1'b1; readdata = 32'hDEAD_0001; response = 2'b00;
        tick();
        readdata = 32'hDEAD_0002;
        tick();
        readdatavalid = 1'b0;
        settle();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, m_read, m_write} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: got %b expected 0000000", {awready, wready, arready, bvalid, rvalid, m_read, m_write});
        end
        checks++;
        if ({bresp, rresp, rdata, m_address, m_writedata, m_byteenable} !== 104'h0) begin
            errors++;
            $display("FAIL rst_mid_data: got %h expected 0", {bresp, rresp, rdata, m_address, m_writedata, m_byteenable});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset = 1'b1;
        awaddr = 32'h0; araddr = 32'h0; wdata = 32'h0; readdata = 32'h0; wstrb = 4'h0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        waitrequest = 1'b0; readdatavalid = 1'b0; writeresponsevalid = 1'b0; response = 2'b00;
        test_reset();
        test_single_write();
        test_read_burst();
        test_contention();
        test_error_mapping();
        test_backpressure();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
